adc_capture_packer: RTL
=======================

ADC_CAPTURE_PACKER -- requirements
Module: adc_capture_packer

Interface
REQ-001 Parameter: CAP_W, default 32, width of cap_size and captured_bytes.
REQ-002 Clock: rf_clk, input, 1 bit, RF data clock (500MHz); the block SHALL use only this clock.
REQ-003 Reset: rf_rstb, input, 1 bit; it SHALL be asynchronous and active-low.
REQ-004 s_axis_tvalid / s_axis_tready / s_axis_tdata: input / output / input, 1 / 1 / 256 bits; ADC samples from the RF data converter, 2x byte-duplicated.
REQ-005 m_axis_tvalid / m_axis_tready / m_axis_tdata / m_axis_tlast: output / input / output / output, 1 / 1 / 256 / 1 bits; packed stream toward the write FIFO and DMA.
REQ-006 cap_start: input, 1 bit; single-cycle pulse that starts a capture.
REQ-007 cap_reset: input, 1 bit; synchronous abort back to IDLE.
REQ-008 cap_size: input, CAP_W bits; capture length in bytes.
REQ-009 busy, done, overflow: outputs, 1 bit each; status flags.
REQ-010 captured_bytes: output, CAP_W bits; bytes emitted so far.

Function
REQ-011 FSM states SHALL be:
- IDLE
- CAPTURE
- FLUSH (last beat pending)
- DONE
REQ-012 IDLE/DONE -> CAPTURE on cap_start when cap_size[CAP_W-1:5] != 0; the FSM SHALL latch cap_size with the low 5 bits cleared, and clear captured_bytes, overflow and the half-select.
REQ-013 cap_start with rounded size 0 SHALL go directly to DONE, with no output beat.
REQ-014 s_axis_tready SHALL be 1 in CAPTURE and 0 in all other states; the ADC is never stalled.
REQ-015 Decimation: on each accepted input beat, half[8k+7:8k] = s_axis_tdata[16k+7:16k] for k = 0..15.
REQ-016 Packing: the first accepted half SHALL go to bits [127:0] and the second to bits [255:128]; completing a pair SHALL load the output register with m_axis_tvalid=1 on the next cycle (1-cycle latency).
REQ-017 The output register SHALL hold data, tvalid and tlast stable until m_axis_tready; tvalid SHALL fall after acceptance unless the register is reloaded in the same cycle.
REQ-018 If a pair completes while m_axis_tvalid && !m_axis_tready: the pair SHALL be dropped, overflow SHALL be set (sticky until the next start or cap_reset), and captured_bytes SHALL NOT advance.
REQ-019 captured_bytes SHALL increment by 32 on each pair loaded into the output register.
REQ-020 m_axis_tlast SHALL be 1 on the loaded beat where captured_bytes+32 == latched size; that load SHALL move the FSM to FLUSH.
REQ-021 FLUSH -> DONE when the tlast beat is accepted.
REQ-022 busy = (CAPTURE or FLUSH); done = DONE.
REQ-023 cap_start SHALL be ignored in CAPTURE and FLUSH.
REQ-024 cap_reset SHALL dominate cap_start in the same cycle. From any state, cap_reset SHALL cause:
- FSM -> IDLE
- m_axis_tvalid=0 and the pending half discarded
- captured_bytes held, overflow cleared
REQ-025 Counter arithmetic SHALL be unsigned CAP_W-bit; maximum capture is 2^CAP_W-32 bytes, with no wrap.

Reset
REQ-026 On rf_rstb low, the block SHALL enter IDLE.
REQ-027 On rf_rstb low, the following outputs SHALL reset to 0:
- m_axis_tvalid, m_axis_tlast, m_axis_tdata
- s_axis_tready, busy, done, overflow, captured_bytes
REQ-028 On rf_rstb low, the half-select and latched size SHALL reset to 0.
REQ-029 Reset asserted mid-capture SHALL abort the capture immediately; no partial beat SHALL be emitted after release.

Structure
REQ-030 Shared package adc_cap_pkg SHALL hold:
- the state enum
- BEAT_BYTES=32
- HALF_W=128
REQ-031 One sub-module adc_halfword_packer SHALL contain the decimation and half-select/pair register; the FSM, counter and output register SHALL stay in the top module.

Verification
REQ-032 cap_size=96, input byte k of beat n = n*16+(k/2), m_axis_tready=1 -> 3 beats; beat0 bytes 0..31 = 0..31; tlast only on beat 2; done=1; captured_bytes=96.
REQ-033 cap_size=100 -> captured_bytes=96 with tlast on the third beat; cap_size=20 -> DONE with no beat.
REQ-034 cap_size=128, m_axis_tready held 0 from beat 1 for 4 cycles -> overflow=1; dropped pairs not counted; tvalid/tdata stable while stalled.
REQ-035 cap_reset pulsed after 3 input beats of a 256-byte capture -> IDLE next cycle, tvalid=0, overflow=0; a new cap_start restarts at half 0.
REQ-036 rf_rstb asserted mid-FLUSH -> all outputs 0 asynchronously; a subsequent capture of cap_size=64 behaves nominally.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared types and constants for the ADC capture packer
package adc_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FLUSH,
    ST_DONE
  } cap_state_t;

  localparam int BEAT_BYTES = 32;
  localparam int BEAT_W     = 256;
  localparam int HALF_W     = 128;

  // The converter repeats every sample byte twice; keep the even bytes only.
  function automatic logic [HALF_W-1:0] decimate(input logic [BEAT_W-1:0] beat);
    logic [HALF_W-1:0] half;
    half = '0;
    for (int k = 0; k < HALF_W / 8; k++) begin
      half[8*k +: 8] = beat[16*k +: 8];
    end
    return half;
  endfunction

endpackage

// File: rtl/adc_halfword_packer.sv
// rtl/adc_halfword_packer.sv - decimates input beats and pairs two halves into one output word
module adc_halfword_packer
  import adc_cap_pkg::*;
(
  input  logic              rf_clk,
  input  logic              rf_rstb,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [BEAT_W-1:0] beat_data,
  output logic              pair_valid,
  output logic [BEAT_W-1:0] pair_data
);

  logic              half_sel;
  logic [HALF_W-1:0] low_half;

  always_ff @(posedge rf_clk or negedge rf_rstb) begin
    if (!rf_rstb) begin
      half_sel <= 1'b0;
      low_half <= '0;
    end else if (clear) begin
      half_sel <= 1'b0;
    end else if (beat_valid) begin
      if (!half_sel) begin
        low_half <= decimate(beat_data);
      end
      half_sel <= ~half_sel;
    end
  end

  // The second half completes the pair combinationally so the top can load it on this edge.
  assign pair_valid = beat_valid && half_sel && !clear;
  assign pair_data  = {decimate(beat_data), low_half};

endmodule

// File: rtl/adc_capture_packer.sv
// rtl/adc_capture_packer.sv - capture FSM, byte counter and output register for the ADC packer
module adc_capture_packer
  import adc_cap_pkg::*;
#(
  parameter int CAP_W = 32
) (
  input  logic              rf_clk,
  input  logic              rf_rstb,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [BEAT_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [BEAT_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              cap_start,
  input  logic              cap_reset,
  input  logic [CAP_W-1:0]  cap_size,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CAP_W-1:0]  captured_bytes
);

  cap_state_t        state;
  logic [CAP_W-1:0]  size_lat;
  logic [CAP_W-1:0]  size_rnd;
  logic [CAP_W-1:0]  bytes_next;
  logic              start_go;
  logic              out_free;
  logic              beat_valid;
  logic              pair_valid;
  logic [BEAT_W-1:0] pair_data;

  assign size_rnd   = cap_size & ~(CAP_W'(BEAT_BYTES - 1));
  assign bytes_next = captured_bytes + CAP_W'(BEAT_BYTES);
  assign start_go   = cap_start && !cap_reset && (size_rnd != '0) &&
                      (state == ST_IDLE || state == ST_DONE);
  assign out_free   = !m_axis_tvalid || m_axis_tready;
  assign beat_valid = s_axis_tvalid && s_axis_tready;

  assign s_axis_tready = (state == ST_CAPTURE);
  assign busy          = (state == ST_CAPTURE) || (state == ST_FLUSH);
  assign done          = (state == ST_DONE);

  adc_halfword_packer u_packer (
    .rf_clk     (rf_clk),
    .rf_rstb    (rf_rstb),
    .clear      (cap_reset || start_go),
    .beat_valid (beat_valid),
    .beat_data  (s_axis_tdata),
    .pair_valid (pair_valid),
    .pair_data  (pair_data)
  );

  always_ff @(posedge rf_clk or negedge rf_rstb) begin
    if (!rf_rstb) begin
      state          <= ST_IDLE;
      size_lat       <= '0;
      captured_bytes <= '0;
      overflow       <= 1'b0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tdata   <= '0;
    end else if (cap_reset) begin
      state         <= ST_IDLE;
      overflow      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (cap_start) begin
            if (size_rnd != '0) begin
              state          <= ST_CAPTURE;
              size_lat       <= size_rnd;
              captured_bytes <= '0;
              overflow       <= 1'b0;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_CAPTURE: begin
          if (pair_valid) begin
            if (out_free) begin
              m_axis_tdata   <= pair_data;
              m_axis_tvalid  <= 1'b1;
              m_axis_tlast   <= (bytes_next == size_lat);
              captured_bytes <= bytes_next;
              if (bytes_next == size_lat) begin
                state <= ST_FLUSH;
              end
            end else begin
              // The ADC cannot be stalled, so a pair with nowhere to go is lost.
              overflow <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
